// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then clocks out one
// byte (LSB first, odd parity, stop) on device clock edges and checks the device ACK.
module ps2_tx #(
   parameter logic [15:0] INHIBIT = 16'd1600,
   parameter logic [15:0] TIMEOUT = 16'd40000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ce,
   inout  wire        ps2Ck,
   inout  wire        ps2DQ,
   input  logic       strb,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_WAITIDLE
   } state_t;

   state_t      state, stateNext;
   logic [15:0] cnt, cntNext;
   logic [3:0]  bitIdx, bitNext;
   logic [7:0]  dataReg, dataNext;
   logic        parityReg, parityNext;
   logic        ckLow, ckLowNext;
   logic        dqLow, dqLowNext;
   logic        busyNext, doneNext, errorNext;

   logic [7:0]  ckShift;
   logic        ckFilt;
   logic        fallEdge;
   logic        dqReg;
   logic        timedOut;

   assign ps2Ck = ckLow ? 1'b0 : 1'bz;
   assign ps2DQ = dqLow ? 1'b0 : 1'bz;

   // Eight-sample debounce of the device clock; a falling edge is a one-tick
   // pulse produced when the filtered level drops.
   always_ff @(posedge clock) begin
      if (reset) begin
         ckShift  <= 8'hFF;
         ckFilt   <= 1'b1;
         fallEdge <= 1'b0;
         dqReg    <= 1'b1;
      end else if (ce) begin
         ckShift  <= {ckShift[6:0], ps2Ck};
         fallEdge <= 1'b0;
         dqReg    <= ps2DQ;
         if (ckShift == 8'hFF) begin
            ckFilt <= 1'b1;
         end else if (ckShift == 8'h00) begin
            ckFilt   <= 1'b0;
            fallEdge <= ckFilt;
         end
      end
   end

   assign timedOut = !fallEdge && (cnt == TIMEOUT - 16'd1);

   // All line drives and status flags are registered so they hold while ce=0.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         bitIdx    <= '0;
         dataReg   <= '0;
         parityReg <= 1'b0;
         ckLow     <= 1'b0;
         dqLow     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (ce) begin
         state     <= stateNext;
         cnt       <= cntNext;
         bitIdx    <= bitNext;
         dataReg   <= dataNext;
         parityReg <= parityNext;
         ckLow     <= ckLowNext;
         dqLow     <= dqLowNext;
         busy      <= busyNext;
         done      <= doneNext;
         error     <= errorNext;
      end
   end

   // The shared counter times the inhibit window first, then the gap between
   // device clock edges once the device is clocking.
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitNext    = bitIdx;
      dataNext   = dataReg;
      parityNext = parityReg;
      ckLowNext  = ckLow;
      dqLowNext  = dqLow;
      busyNext   = busy;
      doneNext   = 1'b0;
      errorNext  = 1'b0;
      case (state)
         ST_IDLE: begin
            ckLowNext = 1'b0;
            dqLowNext = 1'b0;
            busyNext  = 1'b0;
            if (strb) begin
               dataNext   = data;
               parityNext = ~^data;
               busyNext   = 1'b1;
               cntNext    = '0;
               ckLowNext  = 1'b1;
               stateNext  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt == INHIBIT - 16'd1) begin
               dqLowNext = 1'b1;
               stateNext = ST_RTS;
            end else begin
               cntNext = cnt + 16'd1;
            end
         end
         ST_RTS: begin
            ckLowNext = 1'b0;
            bitNext   = '0;
            cntNext   = '0;
            stateNext = ST_SEND;
         end
         ST_SEND: begin
            if (fallEdge) begin
               cntNext = '0;
               bitNext = bitIdx + 4'd1;
               if (bitIdx < 4'd8) begin
                  dqLowNext = ~dataReg[bitIdx[2:0]];
               end else if (bitIdx == 4'd8) begin
                  dqLowNext = ~parityReg;
               end else begin
                  dqLowNext = 1'b0;
                  stateNext = ST_ACK;
               end
            end else if (timedOut) begin
               stateNext = ST_IDLE;
               errorNext = 1'b1;
               busyNext  = 1'b0;
               ckLowNext = 1'b0;
               dqLowNext = 1'b0;
               cntNext   = '0;
            end else begin
               cntNext = cnt + 16'd1;
            end
         end
         ST_ACK: begin
            if (fallEdge) begin
               cntNext = '0;
               if (!dqReg) begin
                  stateNext = ST_WAITIDLE;
               end else begin
                  stateNext = ST_IDLE;
                  errorNext = 1'b1;
                  busyNext  = 1'b0;
                  ckLowNext = 1'b0;
                  dqLowNext = 1'b0;
               end
            end else if (timedOut) begin
               stateNext = ST_IDLE;
               errorNext = 1'b1;
               busyNext  = 1'b0;
               ckLowNext = 1'b0;
               dqLowNext = 1'b0;
               cntNext   = '0;
            end else begin
               cntNext = cnt + 16'd1;
            end
         end
         ST_WAITIDLE: begin
            if (ckFilt && dqReg) begin
               stateNext = ST_IDLE;
               doneNext  = 1'b1;
               busyNext  = 1'b0;
               cntNext   = '0;
            end else if (timedOut) begin
               stateNext = ST_IDLE;
               errorNext = 1'b1;
               busyNext  = 1'b0;
               ckLowNext = 1'b0;
               dqLowNext = 1'b0;
               cntNext   = '0;
            end else if (fallEdge) begin
               cntNext = '0;
            end else begin
               cntNext = cnt + 16'd1;
            end
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: an emulated PS/2 device clocks the host frame while a
// scoreboard checks each done/error pulse against a frame model.
module tb_ps2_tx;

   localparam logic [15:0] INH = 16'd16;
   localparam logic [15:0] TMO = 16'd200;
   localparam int H = 30;

   typedef struct {
      logic [10:0] bits;
      bit          checkBits;
      bit          expDone;
      bit          checkTimeout;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ce = 1'b1;
   logic       strb = 1'b0;
   logic [7:0] data = 8'h00;
   logic       busy, done, error;
   logic       devCk = 1'b1;
   logic       devDq = 1'b1;
   wire        ps2Ck, ps2DQ;

   int          tests = 0;
   int          failures = 0;
   int          cycle = 0;
   int          dqFallCycle = 0;
   logic        prevDq = 1'b1;
   bit          ceRandom = 1'b0;
   logic [10:0] capBits = '0;
   exp_t        sbQ[$];

   pullup (ps2Ck);
   pullup (ps2DQ);
   assign ps2Ck = devCk ? 1'bz : 1'b0;
   assign ps2DQ = devDq ? 1'bz : 1'b0;

   ps2_tx #(.INHIBIT(INH), .TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .ce(ce), .ps2Ck(ps2Ck), .ps2DQ(ps2DQ),
      .strb(strb), .data(data), .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cycle = cycle + 1;
      #1;
      ce = ceRandom ? ($urandom_range(3) != 0) : 1'b1;
   end

   always @(negedge clock) begin
      if (prevDq && !ps2DQ) dqFallCycle = cycle;
      prevDq = ps2DQ;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Frame as the device should see it: start, data LSB first, odd parity, stop.
   function automatic logic [10:0] refFrame(input logic [7:0] d);
      int v, ones;
      logic [10:0] f;
      v = int'(d);
      ones = 0;
      f = '0;
      for (int i = 0; i < 8; i++) begin
         f[i + 1] = ((v >> i) & 1) == 1;
         ones += (v >> i) & 1;
      end
      f[9] = (ones % 2) == 0;
      f[10] = 1'b1;
      return f;
   endfunction

   // Each ce tick that carries a done/error pulse retires one expectation.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (!reset && ce && (done || error)) begin
         if (sbQ.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_pulse: done=%0b error=%0b, expected no pulse", done, error);
         end else begin
            e = sbQ.pop_front();
            checkOutput("done_value", 32'(done), 32'(e.expDone));
            checkOutput("error_value", 32'(error), 32'(!e.expDone));
            checkOutput("busy_at_pulse", 32'(busy), 32'd0);
            if (e.checkBits) checkOutput("frame_bits", 32'(capBits), 32'(e.bits));
            if (e.checkTimeout) checkOutput("timeout_ticks", 32'(cycle - dqFallCycle), 32'(TMO));
         end
      end
   end

   task automatic acceptByte(input logic [7:0] d, input bit poke);
      bit acc;
      acc = 1'b0;
      data = d;
      strb = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         @(posedge clock);
         acc = ce;
      end
      #1;
      strb = 1'b0;
      if (poke) begin
         repeat (3) @(negedge clock);
         data = ~d;
         strb = 1'b1;
         @(posedge clock);
         #1;
         strb = 1'b0;
      end
   endtask

   task automatic runDevice(input int nFalls, input bit ack, input bit glitch, input bit checkTiming);
      int n, m;
      logic [10:0] cap;
      cap = '0;
      n = 0;
      m = 0;
      @(negedge clock);
      while (ps2Ck == 1'b0 && ps2DQ == 1'b1 && n < 20000) begin
         n++;
         @(negedge clock);
      end
      while (ps2Ck == 1'b0 && ps2DQ == 1'b0 && m < 1000) begin
         m++;
         @(negedge clock);
      end
      if (checkTiming) begin
         checkOutput("inhibit_ticks", 32'(n), 32'(INH));
         checkOutput("rts_ticks", 32'(m), 32'd1);
         checkOutput("rts_lines", 32'({ps2Ck, ps2DQ}), 32'b10);
      end
      cap[0] = ps2DQ;
      for (int i = 1; i <= 10 && i <= nFalls; i++) begin
         repeat (H) @(negedge clock);
         devCk = 1'b0;
         repeat (H) @(negedge clock);
         devCk = 1'b1;
         cap[i] = ps2DQ;
         if (glitch && i == 3) begin
            repeat (8) @(negedge clock);
            devCk = 1'b0;
            repeat (5) @(negedge clock);
            devCk = 1'b1;
         end
      end
      capBits = cap;
      if (nFalls >= 11) begin
         repeat (H / 2) @(negedge clock);
         if (ack) devDq = 1'b0;
         repeat (H / 2) @(negedge clock);
         devCk = 1'b0;
         repeat (H) @(negedge clock);
         devCk = 1'b1;
         repeat (5) @(negedge clock);
         devDq = 1'b1;
      end
   endtask

   task automatic waitDrain();
      int g;
      g = 0;
      while (sbQ.size() != 0 && g < 5000) begin
         g++;
         @(negedge clock);
      end
      checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
      repeat (20) @(negedge clock);
      checkOutput("lines_released", 32'({ps2Ck, ps2DQ}), 32'b11);
      checkOutput("busy_idle", 32'(busy), 32'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] d, input int nFalls, input bit ack,
                                input bit glitch, input bit poke);
      exp_t e;
      e.bits = refFrame(d);
      e.checkBits = (nFalls >= 11);
      e.expDone = ack && (nFalls >= 11);
      e.checkTimeout = (nFalls < 11);
      sbQ.push_back(e);
      acceptByte(d, poke);
      runDevice(nFalls, ack, glitch, !ceRandom && !poke);
      waitDrain();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (5) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_error", 32'(error), 32'd0);
      checkOutput("reset_lines", 32'({ps2Ck, ps2DQ}), 32'b11);

      applyStimulus(8'hED, 11, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'hFF, 11, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h00, 11, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h55, 11, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h3C, 11, 1'b1, 1'b0, 1'b1);
      applyStimulus(8'hA7, 11, 1'b0, 1'b0, 1'b0);
      applyStimulus(8'h04, 4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'($urandom), 11, 1'b1, 1'b0, 1'b0);

      acceptByte(8'h5A, 1'b0);
      runDevice(5, 1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      checkOutput("midsend_reset_busy", 32'(busy), 32'd0);
      checkOutput("midsend_reset_lines", 32'({ps2Ck, ps2DQ}), 32'b11);
      checkOutput("midsend_reset_flags", 32'({done, error}), 32'b00);
      reset = 1'b0;
      repeat (5) @(negedge clock);

      ceRandom = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(8'($urandom), 11, 1'b1, 1'b0, 1'b0);
      ceRandom = 1'b0;
      repeat (5) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
